uart_tx_frame_shifter: RTL and testbench
========================================

Name: uart_tx_frame_shifter

Overview:
- Parametrised UART transmit engine. Successor to the fixed 11-bit transmit shift register.
- Builds a complete serial frame: start bit, DATA_W data bits LSB first, optional even/odd parity, then 1 or 2 stop bits.
- Shifts the frame out on Tx, one bit per baud tick from the baud-rate generator.
- Adds a load/ready handshake, an internal bit counter and a frame-done pulse, so the transmit controller no longer sequences bits itself.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 5..9.
- FRAME_W, DATA_W+4, shift-register width: start + data + parity + 2 stop. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  request to send ldata; accepted only when ready=1.
- ldata  in  DATA_W  data word, captured on the accepted load.
- pen  in  1  parity enable, captured with load.
- ohel  in  1  parity sense, captured with load: 1 = odd, 0 = even.
- stop2  in  1  1 = two stop bits, 0 = one; captured with load.
- btu  in  1  one-clock baud-tick enable (bit-time-up).
- Tx  out  1  serial output, idles high.
- ready  out  1  high in IDLE; engine can accept load.
- done  out  1  one-clock pulse when the final stop bit has completed.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of state:
  - State = IDLE; shift register = all 1s; counter = 0.
  - Tx=1, ready=1, done=0 after that edge.
  - A reset mid-frame truncates the frame; Tx returns high at the next edge.
- Tx is driven directly from shreg[0], a registered value with no combinational path from inputs.
- Parity bit P:
  - ohel=0 (even): P = XOR-reduce(ldata).
  - ohel=1 (odd): P = XNOR-reduce(ldata).
- Frame length in bits: FLEN = 1 + DATA_W + pen + 1 + stop2, giving a range of DATA_W+2 .. DATA_W+4.
- Load, in state IDLE with load=1:
  - shreg is loaded LSB to MSB with: 0 (start), ldata[0..DATA_W-1], then the slot bits.
  - Slot bits: P if pen=1, else 1; followed by 1s to fill FRAME_W.
  - Counter = FLEN.
  - State moves to SEND; ready=0 from the next cycle.
  - Tx shows the start bit (0) in the cycle after the load edge.
- SEND state:
  - On each btu=1, shreg shifts right with 1 fill in the MSB, and the counter decrements.
  - When btu=1 with counter==1: state returns to IDLE, done=1 for exactly that following cycle, and Tx is the fill value 1.
  - Each bit therefore occupies one full btu interval. The start bit is held from the load until the first btu.
- Ignored inputs and priorities:
  - btu in IDLE is ignored.
  - load in SEND is ignored: no capture and no effect on the current frame.
  - ldata, pen, ohel and stop2 changes during SEND have no effect.
  - load and btu in the same IDLE cycle: the load is taken and btu is ignored, so the counter is not decremented.
  - The done cycle has ready=1, so a load in that cycle is accepted, giving back-to-back frames with no idle bit.
  - rst has priority over load and btu.
- Counter width: clog2(DATA_W+5) bits; it never wraps because it only decrements from FLEN down to the IDLE transition.

Test Plan:
Bench setup: btu pulses every 4 clocks. Check Tx once per bit interval and count btu pulses up to done.

1. DATA_W=8, ldata=8'hA5, pen=0, stop2=0 -> Tx = 0,1,0,1,0,0,1,0,1,1 (10 bits). done pulses on the 10th btu. ready=0 throughout, then 1.
2. DATA_W=8, ldata=8'hA5, pen=1, then ohel=0 and ohel=1 -> parity bit is 0 (even) and 1 (odd) respectively. Frame is 11 bits; done on the 11th btu.
3. DATA_W=7, ldata=7'h25, pen=1, ohel=0, stop2=1 -> Tx = 0,1,0,1,0,0,1,0,1,1,1 (11 bits). done on the 11th btu.
4. Reset mid-frame: rst=1 after the 4th btu of the scenario-1 frame -> Tx=1, ready=1, done=0 from the next edge. A later load sends a full clean frame.
5. Load while busy: pulse load with ldata=8'h3C during the scenario-1 frame -> the frame bits are unchanged and no second frame follows.
6. Back-to-back: assert load during the done cycle with ldata=8'h0F -> the new start bit appears the next cycle, with no idle gap. btu in IDLE before any load -> Tx stays 1 and done stays 0.

Source files
------------

// File: rtl/uart_tx_frame_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_shifter_if
// Brief    : Load/ready handshake, baud tick and serial output bundle for the
//            UART transmit frame shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_shifter_if #(
  parameter int DATA_W = 8
);
  logic              load;
  logic [DATA_W-1:0] ldata;
  logic              pen;
  logic              ohel;
  logic              stop2;
  logic              btu;
  logic              Tx;
  logic              ready;
  logic              done;

  modport master (
    output load, ldata, pen, ohel, stop2, btu,
    input  Tx, ready, done
  );

  modport slave (
    input  load, ldata, pen, ohel, stop2, btu,
    output Tx, ready, done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_shifter
// Brief    : Parametrised UART transmit engine: builds start/data/parity/stop
//            frame on load and shifts it out LSB first, one bit per baud tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame_shifter #(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = DATA_W + 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  uart_tx_frame_shifter_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 5);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_shreg;
  logic [FRAME_W-1:0] w_shreg_nxt;
  logic [FRAME_W-1:0] w_frame;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_flen;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_par;

  // Odd sense simply inverts the even parity of the data word.
  assign w_par   = (^bus.ldata) ^ bus.ohel;

  // Both stop slots are always 1s; stop2 only lengthens the bit count.
  assign w_frame = {2'b11, (bus.pen ? w_par : 1'b1), bus.ldata, 1'b0};
  assign w_flen  = CNT_W'(DATA_W + 2) + CNT_W'(bus.pen) + CNT_W'(bus.stop2);

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_shreg_nxt = w_frame;
          w_cnt_nxt   = w_flen;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.btu) begin
          w_shreg_nxt = {1'b1, r_shreg[FRAME_W-1:1]};
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '1;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.Tx    = r_shreg[0];
  assign bus.ready = (r_state == IDLE);
  assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame_shifter
// Brief    : Scoreboard bench: frames expected from a bit-list reference model
//            are queued at load and compared when the DUT pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_shifter;

  localparam int DW  = 8;
  localparam int DW7 = 7;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   rst_hit = 1'b0;
  int     checks = 0;
  int     errors = 0;
  frame_t expq[$];

  uart_tx_frame_shifter_if #(.DATA_W(DW))  bus ();
  uart_tx_frame_shifter_if #(.DATA_W(DW7)) bus7 ();

  uart_tx_frame_shifter #(.DATA_W(DW))  dut  (.clk(clk), .rst(rst), .bus(bus));
  uart_tx_frame_shifter #(.DATA_W(DW7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  always #5 clk = ~clk;

  assign bus7.btu = bus.btu;

  always @(posedge clk) rst_hit <= rst;

  // Frame as a plain bit list: start, data LSB first, optional parity, stops.
  function automatic frame_t model(input logic [8:0] data, input int dw,
                                   input logic pen, input logic ohel, input logic stop2);
    frame_t f;
    int     ones;
    ones    = 0;
    f.bits  = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < dw; i++) begin
      f.bits[1+i] = data[i];
      if (data[i]) ones++;
    end
    f.len = 1 + dw;
    if (pen) begin
      f.bits[f.len] = ((ones % 2) == 1) ? ~ohel : ohel;
      f.len++;
    end
    f.bits[f.len] = 1'b1;
    f.len++;
    if (stop2) begin
      f.bits[f.len] = 1'b1;
      f.len++;
    end
    return f;
  endfunction

  function automatic logic [31:0] mask(input int n);
    return (32'h1 << n) - 32'h1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Free-running baud tick, one clock high every 4 clocks.
  initial begin
    bus.btu = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.btu = 1'b1;
      @(posedge clk);
      #1 bus.btu = 1'b0;
    end
  end

  // Monitor: collects one Tx sample per bit interval, compares on done.
  initial begin : mon
    bit          active;
    bit          pb;
    bit          bad_ready;
    logic [31:0] got;
    int          gotn;
    frame_t      e;
    active    = 1'b0;
    pb        = 1'b0;
    bad_ready = 1'b0;
    got       = '1;
    gotn      = 0;
    forever begin
      @(negedge clk);
      if (rst_hit) begin
        active = 1'b0;
        expq.delete();
      end else if (active && bus.done) begin
        check("done_tx_high", 32'(bus.Tx), 32'd1);
        check("done_ready_high", 32'(bus.ready), 32'd1);
        check("ready_low_in_frame", 32'(bad_ready), 32'd0);
        if (expq.size() == 0) begin
          fail_now("unexpected_frame_bits", gotn, 0);
        end else begin
          e = expq.pop_front();
          check("frame_len", 32'(gotn), 32'(e.len));
          check("frame_bits", got & mask(e.len), {16'h0, e.bits} & mask(e.len));
        end
        active = 1'b0;
      end else if (!active && bus.done) begin
        fail_now("spurious_done", 1, 0);
      end else if (!active && !bus.ready) begin
        active    = 1'b1;
        bad_ready = 1'b0;
        got       = '1;
        got[0]    = bus.Tx;
        gotn      = 1;
      end else if (active) begin
        if (pb) begin
          if (gotn < 32) got[gotn] = bus.Tx;
          gotn++;
        end
        if (bus.ready) bad_ready = 1'b1;
        if (gotn > 20) begin
          fail_now("overlong_frame", gotn, 20);
          active = 1'b0;
        end
      end
      pb = bus.btu;
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input logic o, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) fail_now("send_ready_timeout", 0, 1);
    bus.ldata = d;
    bus.pen   = p;
    bus.ohel  = o;
    bus.stop2 = s;
    bus.load  = 1'b1;
    expq.push_back(model({1'b0, d}, DW, p, o, s));
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic junk_load(input logic [7:0] d);
    if (!bus.ready) begin
      bus.ldata = d;
      bus.pen   = 1'(($urandom) & 1);
      bus.ohel  = 1'(($urandom) & 1);
      bus.stop2 = 1'(($urandom) & 1);
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((expq.size() != 0 || !bus.ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(expq.size()), 32'd0);
  endtask

  initial begin : stim
    bit          bad;
    bit          pb;
    int          n7;
    int          nb;
    logic [31:0] g7;
    frame_t      e7;
    bus.load  = 1'b0;  bus.ldata = '0;  bus.pen  = 1'b0;
    bus.ohel  = 1'b0;  bus.stop2 = 1'b0;
    bus7.load = 1'b0;  bus7.ldata = '0; bus7.pen = 1'b0;
    bus7.ohel = 1'b0;  bus7.stop2 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.Tx), 32'd1);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Baud ticks while idle must not disturb the line.
    bad = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (bus.Tx !== 1'b1 || bus.done !== 1'b0 || bus.ready !== 1'b1) bad = 1'b1;
    end
    check("idle_btu_ignored", 32'(bad), 32'd0);

    // 7-bit instance: 0x25, even parity, two stops.
    @(negedge clk);
    bus7.ldata = 7'h25; bus7.pen = 1'b1; bus7.ohel = 1'b0; bus7.stop2 = 1'b1;
    bus7.load  = 1'b1;
    @(negedge clk);
    bus7.load  = 1'b0;
    g7 = '1; g7[0] = bus7.Tx; n7 = 1; pb = bus7.btu;
    for (int k = 0; k < 200 && !bus7.done; k++) begin
      @(negedge clk);
      if (!bus7.done && pb) begin
        if (n7 < 32) g7[n7] = bus7.Tx;
        n7++;
      end
      pb = bus7.btu;
    end
    e7 = model({2'b00, 7'h25}, DW7, 1'b1, 1'b0, 1'b1);
    check("dw7_done", 32'(bus7.done), 32'd1);
    check("dw7_len", 32'(n7), 32'd11);
    check("dw7_bits", g7 & mask(11), 32'h74A);
    check("dw7_model", g7 & mask(e7.len), {16'h0, e7.bits} & mask(e7.len));

    // Plain, even-parity and odd-parity frames.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Load while busy is ignored and no second frame follows.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    junk_load(8'h3C);
    wait_idle();
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready !== 1'b1 || bus.Tx !== 1'b1) bad = 1'b1;
    end
    check("no_frame_after_busy_load", 32'(bad), 32'd0);

    // Reset after the 4th baud tick truncates the frame.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    nb = 0;
    for (int k = 0; k < 200 && nb < 4; k++) begin
      @(negedge clk);
      if (bus.btu) nb++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", 32'(bus.Tx), 32'd1);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    send(8'h5A, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // Back-to-back: load in the done cycle starts the next frame at once.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    nb = 0;
    while (!bus.done && nb < 200) begin
      @(negedge clk);
      nb++;
    end
    check("b2b_done_seen", 32'(bus.done), 32'd1);
    bus.ldata = 8'h0F; bus.pen = 1'b0; bus.ohel = 1'b0; bus.stop2 = 1'b0;
    bus.load  = 1'b1;
    expq.push_back(model({1'b0, 8'h0F}, DW, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    bus.load  = 1'b0;
    check("b2b_start_bit", 32'(bus.Tx), 32'd0);
    check("b2b_ready_low", 32'(bus.ready), 32'd0);
    wait_idle();

    // Randomised frames with random gaps and stray loads while busy.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(8'($urandom), 1'(($urandom) & 1), 1'(($urandom) & 1), 1'(($urandom) & 1));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        junk_load(8'($urandom));
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
